// File: rtl/flow_stream_monitor_if.sv
// flow_stream_monitor_if: flow vector stream in, statistics record out
interface flow_stream_monitor_if #(
  parameter int FLOW_WIDTH = 16,
  parameter int SUM_WIDTH  = 40,
  parameter int CNT_WIDTH  = 17,
  parameter int LAT_WIDTH  = 20
);
  logic signed [FLOW_WIDTH-1:0] flow_u;
  logic signed [FLOW_WIDTH-1:0] flow_v;
  logic                         flow_valid;
  logic signed [SUM_WIDTH-1:0]  sum_u;
  logic signed [SUM_WIDTH-1:0]  sum_v;
  logic [CNT_WIDTH-1:0]         region_count;
  logic [CNT_WIDTH-1:0]         total_count;
  logic [LAT_WIDTH-1:0]         latency_cycles;
  logic                         overrun;
  logic                         stats_valid;
  logic                         stats_ready;
  modport master (
    output flow_u, flow_v, flow_valid, stats_ready,
    input  sum_u, sum_v, region_count, total_count, latency_cycles, overrun, stats_valid
  );
  modport slave (
    input  flow_u, flow_v, flow_valid, stats_ready,
    output sum_u, sum_v, region_count, total_count, latency_cycles, overrun, stats_valid
  );
endinterface

// File: rtl/flow_stream_monitor.sv
// flow_stream_monitor: per-frame region statistics and start-to-first-vector latency
module flow_stream_monitor #(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240,
  parameter int BORDER       = 4,
  parameter int FLOW_WIDTH   = 16,
  parameter int COORD_WIDTH  = 10,
  parameter int SUM_WIDTH    = 40,
  parameter int CNT_WIDTH    = 17,
  parameter int LAT_WIDTH    = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   frame_done,
  input  logic [COORD_WIDTH-1:0] region_x_min,
  input  logic [COORD_WIDTH-1:0] region_x_max,
  input  logic [COORD_WIDTH-1:0] region_y_min,
  input  logic [COORD_WIDTH-1:0] region_y_max,
  output logic                   busy,
  flow_stream_monitor_if.slave   fs
);
  localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(IMAGE_WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] Y_LAST = COORD_WIDTH'(IMAGE_HEIGHT - 1);
  localparam logic [COORD_WIDTH-1:0] B      = COORD_WIDTH'(BORDER);
  localparam int EXT = SUM_WIDTH - FLOW_WIDTH;
  typedef enum logic [1:0] {IDLE, ARMED, STREAM, REPORT} state_t;
  state_t state, state_nx;
  logic [COORD_WIDTH-1:0] x, y;
  logic [LAT_WIDTH-1:0] lat_cnt;
  logic end_flag, take, in_region, last_col, last_row;
  assign take      = busy && fs.flow_valid && !end_flag;
  assign in_region = x >= region_x_min && x <= region_x_max && y >= region_y_min && y <= region_y_max;
  assign last_col  = x == X_LAST;
  assign last_row  = y == Y_LAST;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb
    state_nx = state == IDLE   ? (start ? ARMED : IDLE)
             : state == REPORT ? (fs.stats_ready ? IDLE : REPORT)
             : frame_done      ? REPORT
             : (state == ARMED && fs.flow_valid) ? STREAM : state;
  always_comb begin
    busy           = state == ARMED || state == STREAM;
    fs.stats_valid = state == REPORT;
  end
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start)) begin
      fs.sum_u          <= '0;
      fs.sum_v          <= '0;
      fs.region_count   <= '0;
      fs.total_count    <= '0;
      fs.latency_cycles <= '0;
      fs.overrun        <= 1'b0;
      end_flag          <= 1'b0;
      x                 <= rst ? '0 : B;
      y                 <= rst ? '0 : B;
      lat_cnt           <= rst ? '0 : LAT_WIDTH'(1);
    end else if (busy) begin
      if (state == ARMED && !fs.flow_valid && lat_cnt != '1)
        lat_cnt <= lat_cnt + 1'b1;
      if (state == ARMED && fs.flow_valid)
        fs.latency_cycles <= lat_cnt;
      if (fs.flow_valid && end_flag)
        fs.overrun <= 1'b1;
      if (take) begin
        fs.total_count <= fs.total_count + 1'b1;
        if (in_region) begin
          fs.sum_u        <= fs.sum_u + {{EXT{fs.flow_u[FLOW_WIDTH-1]}}, fs.flow_u};
          fs.sum_v        <= fs.sum_v + {{EXT{fs.flow_v[FLOW_WIDTH-1]}}, fs.flow_v};
          fs.region_count <= fs.region_count + 1'b1;
        end
        // last vector of the frame parks the position; later vectors count as overrun
        if (last_col && last_row)
          end_flag <= 1'b1;
        else if (last_col) begin
          x <= B;
          y <= y + 1'b1;
        end else
          x <= x + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_flow_stream_monitor.sv
// tb_flow_stream_monitor: table-driven frame scenarios plus handshake/reset sequences
module tb_flow_stream_monitor;
  localparam int FRAME = 74576;
  typedef struct {
    int xmin, xmax, ymin, ymax, gap, n, u, v;
    longint rc, su, sv, tc, lat, ovr;
  } rec_t;
  logic clk = 1'b0;
  logic rst, start, frame_done, busy;
  logic [9:0] region_x_min, region_x_max, region_y_min, region_y_max;
  int n_cmp = 0, n_err = 0;
  rec_t tbl[6];
  flow_stream_monitor_if s();
  flow_stream_monitor dut (
    .clk(clk), .rst(rst), .start(start), .frame_done(frame_done),
    .region_x_min(region_x_min), .region_x_max(region_x_max),
    .region_y_min(region_y_min), .region_y_max(region_y_max),
    .busy(busy), .fs(s.slave)
  );
  always #5 clk = ~clk;
  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_sum_u"}, s.sum_u, 0);
    chk({tag, "_sum_v"}, s.sum_v, 0);
    chk({tag, "_region_count"}, s.region_count, 0);
    chk({tag, "_total_count"}, s.total_count, 0);
    chk({tag, "_latency"}, s.latency_cycles, 0);
    chk({tag, "_overrun"}, s.overrun, 0);
    chk({tag, "_stats_valid"}, s.stats_valid, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask
  task automatic do_frame(input rec_t r);
    int k;
    region_x_min = 10'(r.xmin);
    region_x_max = 10'(r.xmax);
    region_y_min = 10'(r.ymin);
    region_y_max = 10'(r.ymax);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (r.gap) @(negedge clk);
    for (int i = 0; i < r.n; i++) begin
      s.flow_valid = 1'b1;
      s.flow_u = 16'(r.u);
      s.flow_v = 16'(r.v);
      @(negedge clk);
      if (i + 1 == FRAME) begin
        chk("frame_total", s.total_count, FRAME);
        chk("frame_overrun_clear", s.overrun, 0);
      end
    end
    s.flow_valid = 1'b0;
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
    k = 0;
    while (!s.stats_valid && k < 8) begin
      @(negedge clk);
      k++;
    end
    chk("report_reached", s.stats_valid, 1);
  endtask
  task automatic check_rec(input rec_t r, input string tag);
    chk({tag, "_region_count"}, s.region_count, r.rc);
    chk({tag, "_sum_u"}, s.sum_u, r.su);
    chk({tag, "_sum_v"}, s.sum_v, r.sv);
    chk({tag, "_total_count"}, s.total_count, r.tc);
    chk({tag, "_latency"}, s.latency_cycles, r.lat);
    chk({tag, "_overrun"}, s.overrun, r.ovr);
    chk({tag, "_busy"}, busy, 0);
  endtask
  task automatic release_rec(input string tag);
    s.stats_ready = 1'b1;
    @(negedge clk);
    s.stats_ready = 1'b0;
    chk({tag, "_released_valid"}, s.stats_valid, 0);
    chk({tag, "_released_busy"}, busy, 0);
  endtask
  initial begin
    tbl[0] = '{55, 85, 105, 135, 0, FRAME + 2, 256, -13, 961, 246016, -12493, FRAME, 1, 1};
    tbl[1] = '{4, 319, 4, 239, 7, 3, 5, -2, 3, 15, -6, 3, 8, 0};
    tbl[2] = '{319, 319, 4, 5, 0, 632, -128, 0, 2, -256, 0, 632, 1, 0};
    tbl[3] = '{4, 4, 5, 5, 0, 317, 3, 7, 1, 3, 7, 317, 1, 0};
    tbl[4] = '{4, 319, 4, 239, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[5] = '{10, 12, 4, 4, 0, 20, -1, 100, 3, -3, 300, 20, 1, 0};
    rst = 1'b1;
    start = 1'b0;
    frame_done = 1'b0;
    s.flow_valid = 1'b0;
    s.flow_u = '0;
    s.flow_v = '0;
    s.stats_ready = 1'b0;
    region_x_min = '0;
    region_x_max = '0;
    region_y_min = '0;
    region_y_max = '0;
    for (int i = 0; i < 3; i++) begin
      s.flow_valid = i[0];
      @(negedge clk);
    end
    rst = 1'b0;
    s.flow_valid = 1'b0;
    check_zero("reset");
    for (int t = 0; t < 6; t++) begin
      do_frame(tbl[t]);
      check_rec(tbl[t], $sformatf("vec%0d", t));
      release_rec($sformatf("vec%0d", t));
    end
    // REPORT holds while stats_ready is low, ignoring start and flow_valid
    do_frame(tbl[5]);
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      s.flow_valid = 1'b1;
      s.flow_u = 16'sd50;
      s.flow_v = 16'sd50;
      @(negedge clk);
      chk("hold_valid", s.stats_valid, 1);
      chk("hold_total", s.total_count, tbl[5].tc);
      chk("hold_sum_v", s.sum_v, tbl[5].sv);
    end
    start = 1'b0;
    s.flow_valid = 1'b0;
    release_rec("hold");
    @(negedge clk);
    chk("hold_idle_busy", busy, 0);
    // reset mid-stream on vector 1000
    region_x_min = 10'd4;
    region_x_max = 10'd319;
    region_y_min = 10'd4;
    region_y_max = 10'd239;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      s.flow_valid = 1'b1;
      s.flow_u = 16'sd9;
      s.flow_v = -16'sd9;
      rst = (i == 999);
      @(negedge clk);
    end
    rst = 1'b0;
    s.flow_valid = 1'b0;
    check_zero("midrst");
    do_frame(tbl[5]);
    check_rec(tbl[5], "after_rst");
    release_rec("after_rst");
    // reset while in REPORT
    do_frame(tbl[1]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("rptrst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/flow_stream_monitor.md
Name: flow_stream_monitor

Overview:
- Hardware sink for the optical flow output stream: consumes flow_u/flow_v/flow_valid from optical_flow_top and tracks the raster position of each vector.
- Accumulates per-frame statistics over a programmable rectangular region and measures start-to-first-output latency.
- Presents a result record over a valid/ready handshake. Sits beside optical_flow_top for on-chip self-check and for debug readout.

Parameters:
IMAGE_WIDTH, 320, frame width in pixels
IMAGE_HEIGHT, 240, frame height in pixels
BORDER, 4, first valid column/row of the flow output
FLOW_WIDTH, 16, S8.7 signed flow component width
COORD_WIDTH, 10, coordinate/region bound width
SUM_WIDTH, 40, signed accumulator width
CNT_WIDTH, 17, vector counter width
LAT_WIDTH, 20, latency counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  single-cycle pulse, same cycle as optical_flow_top start
frame_done  in  1  optical_flow_top done
flow_u  in  FLOW_WIDTH  signed S8.7 horizontal flow
flow_v  in  FLOW_WIDTH  signed S8.7 vertical flow
flow_valid  in  1  flow sample valid
region_x_min  in  COORD_WIDTH  inclusive region bound
region_x_max  in  COORD_WIDTH  inclusive region bound
region_y_min  in  COORD_WIDTH  inclusive region bound
region_y_max  in  COORD_WIDTH  inclusive region bound
busy  out  1  high in ARMED or STREAM
sum_u  out  SUM_WIDTH  signed sum of in-region flow_u
sum_v  out  SUM_WIDTH  signed sum of in-region flow_v
region_count  out  CNT_WIDTH  in-region vector count
total_count  out  CNT_WIDTH  accepted vector count
latency_cycles  out  LAT_WIDTH  start-to-first-valid latency
overrun  out  1  more vectors than one frame holds
stats_valid  out  1  result record valid
stats_ready  in  1  consumer accepts record

Behaviour:
- Reset: state IDLE. All outputs 0, internal x/y/latency/end flag cleared. Region bounds are sampled live; they must be held stable while busy.
- FSM IDLE -> ARMED on start. Entering ARMED clears sums, counts, overrun and end flag, loads x=y=BORDER, and loads the latency counter to 1.
- ARMED, each cycle:
  - flow_valid = 0: latency counter +1, saturating at all-ones.
  - flow_valid = 1: latency_cycles <= counter, sample processed, -> STREAM.
  - Result: a flow_valid on the first cycle after the start edge gives latency 1.
- Sample processing (ARMED/STREAM, flow_valid = 1, end flag = 0):
  - total_count +1.
  - If x_min <= x <= x_max and y_min <= y <= y_max: sum_u += sign-extended flow_u, sum_v += sign-extended flow_v, region_count +1.
  - Position advance: if x == IMAGE_WIDTH-1, then x <= BORDER and y +1; otherwise x +1.
  - At x = IMAGE_WIDTH-1 and y = IMAGE_HEIGHT-1, set the end flag instead of advancing.
- flow_valid while the end flag is set: overrun <= 1 (sticky), sample discarded, counts unchanged.
- frame_done in ARMED or STREAM -> REPORT. A flow_valid in the same cycle is still processed. If frame_done arrives in ARMED, latency_cycles stays 0.
- REPORT: stats_valid = 1 and all result outputs held constant. stats_valid & stats_ready -> IDLE next cycle, and stats_valid deasserts.
- start outside IDLE is ignored. flow_valid in IDLE/REPORT is ignored.
- rst at any point, including mid-stream or in REPORT, returns to the reset state on the next edge.
- Full frame holds (IMAGE_WIDTH-BORDER)*(IMAGE_HEIGHT-BORDER) = 74576 vectors at defaults.

Test Plan:
- Reset: hold rst 3 cycles with flow_valid toggling -> all outputs 0, busy 0, stats_valid 0.
- Constant flow: region [55..85]x[105..135], start, 74576 valids with flow_u=256 (2.0), flow_v=-13, then frame_done -> region_count=961, sum_u=246016, sum_v=-12493, total_count=74576, overrun 0.
- Latency: start, flow_valid low for 7 cycles, first valid on the 8th edge after start -> latency_cycles=8. frame_done without any valid -> latency_cycles=0.
- Row wrap: region x=[319..319], y=[4..5], 632 valids with flow_u=-128 -> region_count=2, sum_u=-256. Also check the vector after (319,4) lands at (4,5): region x=[4..4], y=[5..5] -> region_count=1.
- Handshake: in REPORT hold stats_ready=0 for 5 cycles and pulse start -> outputs stable, still REPORT. Raise stats_ready -> IDLE next cycle, stats_valid 0.
- Overrun/reset: 74578 valids -> total_count=74576, overrun=1. Separately assert rst at vector 1000 -> all outputs 0 next cycle, and a new start runs cleanly.
